score_display: RTL and testbench

- Scoreboard back-end for the bouncing-ball game; it consumes the game core's `lose` indication.
- Counts accepted lose events in a 4-digit BCD counter and drives a time-multiplexed, active-low 4-digit seven-segment display.
- Sits beside the VGA display path at top level, on the same system clock.
- Purely sequential: edge detection, hold-off timer, BCD counter, scan counter, registered segment outputs.

---
 rtl/score_pkg.sv | 42 ++++
 rtl/score_display_if.sv | 15 +
 rtl/seg_decoder.sv | 26 ++
 rtl/score_display.sv | 98 +++++++++
 tb/tb_score_display.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score display path: BCD digit/score
// vectors, active-low seven-segment patterns and a BCD increment helper.
package score_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0]                  bcd_digit_t;
    typedef logic [NUM_DIGITS-1:0][3:0]  score_t;

    // Active-low gfedcba, seg[6]=g ... seg[0]=a
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Ripple-carry decimal increment; all-nines wraps to zero.
    function automatic score_t bcd_inc(input score_t s);
        score_t r;
        logic   carry;
        r     = s;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (r[i] == 4'd9) begin
                    r[i] = 4'd0;
                end else begin
                    r[i]  = r[i] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// Game-core/display side signals of the scoreboard: lose/clr in, score and
// multiplexed seven-segment drive out.
interface score_display_if;
    import score_pkg::*;

    logic                  lose;
    logic                  clr;
    score_t                score;
    logic [NUM_DIGITS-1:0] select;
    logic [6:0]            seg;

    modport master (output lose, clr, input  score, select, seg);
    modport slave  (input  lose, clr, output score, select, seg);

endinterface

// File: rtl/seg_decoder.sv
// BCD digit to active-low seven-segment pattern; non-BCD codes go dark.
module seg_decoder
    import score_pkg::*;
(
    input  bcd_digit_t digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Counts debounced lose events in BCD and scans them onto a 4-digit
// active-low seven-segment display.
module score_display
    import score_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLDOFF     = 1000000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input logic            clk,
    input logic            rst,
    score_display_if.slave bus
);

    localparam int HOLD_W = $clog2(HOLDOFF + 1);
    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    score_t                         score_r;
    logic                           lose_q;
    logic [HOLD_W-1:0]              holdoff;
    logic [REF_W-1:0]               ref_cnt;
    logic [IDX_W-1:0]               idx;
    logic                           rise;
    logic                           accept;
    logic [NUM_DIGITS-1:0][6:0]     dig_seg;
    logic [NUM_DIGITS-1:0]          blank_vec;
    logic                           zero_above;
    logic [NUM_DIGITS-1:0]          select_r;
    logic [6:0]                     seg_r;

    assign rise   = bus.lose & ~lose_q;
    assign accept = rise & (holdoff == '0) & ~bus.clr;

    // clr beats a coincident rise and also drops any pending hold-off
    always_ff @(posedge clk) begin
        if (rst) begin
            score_r <= '0;
            lose_q  <= 1'b0;
            holdoff <= '0;
        end else begin
            lose_q <= bus.lose;
            if (bus.clr) begin
                score_r <= '0;
                holdoff <= '0;
            end else if (accept) begin
                score_r <= bcd_inc(score_r);
                holdoff <= HOLD_W'(HOLDOFF);
            end else if (holdoff != '0) begin
                holdoff <= holdoff - HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= idx + IDX_W'(1);
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg_decoder u_dec (
            .digit (score_r[g]),
            .seg   (dig_seg[g])
        );
    end

    // Digit k>0 is a leading zero when it and every digit above it are zero
    always_comb begin
        zero_above = 1'b1;
        blank_vec  = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_above   = zero_above & (score_r[k] == 4'd0);
            blank_vec[k] = zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            select_r <= ~NUM_DIGITS'(1);
            seg_r    <= SEG_0;
        end else begin
            select_r <= ~(NUM_DIGITS'(1) << idx);
            seg_r    <= (BLANK_LZ && blank_vec[idx]) ? SEG_BLANK : dig_seg[idx];
        end
    end

    assign bus.score  = score_r;
    assign bus.select = select_r;
    assign bus.seg    = seg_r;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: a cycle model pushes expected
// score/select/seg per edge, a negedge checker pops and compares.
module tb_score_display;

    localparam int RDIV = 4;
    localparam int HOLD = 8;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_w = 1'b1;

    always #5 clk = ~clk;

    score_display_if ifc ();
    score_display_if ifw ();

    score_display #(.REFRESH_DIV(RDIV), .HOLDOFF(HOLD), .BLANK_LZ(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // Short hold-off copy so the 9999 wrap is reachable in few cycles
    score_display #(.REFRESH_DIV(RDIV), .HOLDOFF(1), .BLANK_LZ(1'b1)) dut_w (
        .clk (clk),
        .rst (rst_w),
        .bus (ifw.slave)
    );

    typedef struct packed {
        logic [15:0] score;
        logic [3:0]  sel;
        logic [6:0]  seg;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    int   m_score = 0;
    int   m_hold  = 0;
    int   m_ref   = 0;
    int   m_idx   = 0;
    logic m_lose_q = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Drive one cycle on the main DUT and push what it must show afterwards
    task automatic step(input logic l, input logic c);
        exp_t e;
        ifc.lose = l;
        ifc.clr  = c;
        @(posedge clk);
        if (rst) begin
            e.sel    = 4'b1110;
            e.seg    = 7'b1000000;
            m_score  = 0;
            m_hold   = 0;
            m_lose_q = 1'b0;
            m_ref    = 0;
            m_idx    = 0;
        end else begin
            e.sel = ~(4'b0001 << m_idx);
            if (m_idx > 0 && m_score < pow10(m_idx))
                e.seg = 7'h7F;
            else
                e.seg = seg_of((m_score / pow10(m_idx)) % 10);
            if (m_ref == RDIV - 1) begin
                m_ref = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_ref++;
            end
            if (c) begin
                m_score = 0;
                m_hold  = 0;
            end else if (l && !m_lose_q && m_hold == 0) begin
                m_score = (m_score + 1) % 10000;
                m_hold  = HOLD;
            end else if (m_hold > 0) begin
                m_hold--;
            end
            m_lose_q = l;
        end
        e.score = to_bcd(m_score);
        sb_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("score",  ifc.score,  e.score);
            chk("select", ifc.select, e.sel);
            chk("seg",    ifc.seg,    e.seg);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic pulse_w();
        ifw.lose = 1'b1;
        @(posedge clk);
        #1;
        ifw.lose = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] seen [4];
        logic       found;
        ifc.lose = 1'b0;
        ifc.clr  = 1'b0;
        ifw.lose = 1'b0;
        ifw.clr  = 1'b0;

        // 1: reset, idle scan with leading-zero blanking
        do_reset();
        idle(40);

        // 2: single pulse, then a long held level counts once
        do_reset();
        idle(10);
        step(1'b1, 1'b0);
        chk("pulse_count", ifc.score, 16'h0001);
        idle(12);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
        idle(12);
        chk("held_count", ifc.score, 16'h0002);

        // 3: rises at 10, 14, 19 -> middle one falls in hold-off
        do_reset();
        idle(10);
        step(1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b0);
        idle(10);
        chk("holdoff_count", ifc.score, 16'h0002);

        // 5: clr beats a coincident eligible rise; later rise accepted
        step(1'b1, 1'b1);
        chk("clr_wins", ifc.score, 16'h0000);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("after_clr", ifc.score, 16'h0001);
        // clr during hold-off must drop the pending hold-off
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("clr_drops_hold", ifc.score, 16'h0001);
        idle(12);

        // 4: wrap behaviour on the short hold-off instance
        rst_w = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_w = 1'b0;
        repeat (999) pulse_w();
        chk("wrap_0999", ifw.score, 16'h0999);
        pulse_w();
        chk("wrap_1000", ifw.score, 16'h1000);
        for (int k = 0; k < 4; k++) seen[k] = 7'h7F;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++)
                if (ifw.select == ~(4'b0001 << k)) seen[k] = ifw.seg;
        end
        chk("d1000_ones",  seen[0], 7'b1000000);
        chk("d1000_tens",  seen[1], 7'b1000000);
        chk("d1000_hund",  seen[2], 7'b1000000);
        chk("d1000_thou",  seen[3], 7'b1111001);
        repeat (8999) pulse_w();
        chk("wrap_9999", ifw.score, 16'h9999);
        pulse_w();
        chk("wrap_0000", ifw.score, 16'h0000);

        // 6: reset mid-scan at idx 2 with score 42
        do_reset();
        for (int i = 0; i < 42; i++) begin
            step(1'b1, 1'b0);
            idle(HOLD);
        end
        chk("pre_rst_score", ifc.score, 16'h0042);
        found = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            if (m_idx == 2 && m_ref == 1) found = 1'b1;
            else step(1'b0, 1'b0);
        end
        chk("reach_idx2", {31'd0, found}, 32'd1);
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_score",  ifc.score,  16'h0000);
        chk("rst_select", ifc.select, 4'b1110);
        chk("rst_seg",    ifc.seg,    7'b1000000);
        idle(20);

        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
